wshb_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter sharing the SDRAM controller port.
- Master 0 is the video framebuffer reader, which streams into the display FIFO and holds cyc high continuously.
- Master 1 is the framebuffer writer (pattern generator or host bridge).
- Grants are round-robin, with a per-grant transfer quota, so a master that never drops cyc cannot starve the other.

---
 rtl/wshb_arbiter2.sv | 193 +++++++++++++++++++
 tb/tb_wshb_arbiter2.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter2.sv
// wshb_arbiter2
// Two-master, one-slave Wishbone arbiter for the shared SDRAM controller port.
// Master 0 is the video framebuffer reader, which keeps cyc high while it
// streams. Master 1 is the framebuffer writer. Grants alternate round-robin.
// Each grant has a quota of MAX_BURST acknowledged transfers. Once the quota
// is used up, the grant is taken away at the next burst boundary, but only if
// the other master is waiting.
//
// Ports:
//   clk, rst          Wishbone clock, asynchronous active-high reset
//   m0_* / m1_*       master-side Wishbone buses (cyc, stb, we, adr, sel,
//                     dat_ms, cti, bte in; ack, dat_sm out)
//   s_*               slave-side Wishbone bus towards the SDRAM controller
//   grant             one-hot current owner {GNT1, GNT0}; 00 means idle
module wshb_arbiter2 #(
  parameter int MAX_BURST = 64,
  parameter int ADR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [ADR_WIDTH-1:0] m0_adr,
  input  logic [3:0]           m0_sel,
  input  logic [31:0]          m0_dat_ms,
  input  logic [2:0]           m0_cti,
  input  logic [1:0]           m0_bte,
  output logic                 m0_ack,
  output logic [31:0]          m0_dat_sm,

  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [ADR_WIDTH-1:0] m1_adr,
  input  logic [3:0]           m1_sel,
  input  logic [31:0]          m1_dat_ms,
  input  logic [2:0]           m1_cti,
  input  logic [1:0]           m1_bte,
  output logic                 m1_ack,
  output logic [31:0]          m1_dat_sm,

  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADR_WIDTH-1:0] s_adr,
  output logic [3:0]           s_sel,
  output logic [31:0]          s_dat_ms,
  output logic [2:0]           s_cti,
  output logic [1:0]           s_bte,
  input  logic                 s_ack,
  input  logic [31:0]          s_dat_sm,

  output logic [1:0]           grant
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] QUOTA_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CNT_W-1:0] ack_cnt;

  logic req0;
  logic req1;
  logic end0;
  logic end1;
  logic quota_done;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // A grant may only be taken away on a classic cycle or on the final beat
  // of a burst. An incrementing burst is never broken.
  assign end0 = (m0_cti == 3'b000) || (m0_cti == 3'b111);
  assign end1 = (m1_cti == 3'b000) || (m1_cti == 3'b111);

  // Using ">=" covers two cases. The first is the ack that completes the
  // quota (count == MAX_BURST-1). The second is any later ack after the
  // counter has saturated, which happens when the quota ran out mid-burst
  // or while the other master was idle.
  assign quota_done = s_ack && (ack_cnt >= QUOTA_LAST);

  // State register. An asynchronous reset drops the slave cycle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping. The fairness pointer and the quota counter restart
  // each time a grant is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= 1'b1;
      ack_cnt <= '0;
    end else if (state == IDLE && state_nxt == GNT0) begin
      last    <= 1'b0;
      ack_cnt <= '0;
    end else if (state == IDLE && state_nxt == GNT1) begin
      last    <= 1'b1;
      ack_cnt <= '0;
    end else if (state != IDLE && s_ack && ack_cnt != CNT_SAT) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end

  // Next-state logic. Every release passes through IDLE for one cycle. That
  // gap, combined with the updated last pointer, hands the bus across.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc || (quota_done && req1 && end0)) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc || (quota_done && req0 && end1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The slave bus follows the owner indicated by the
  // registered state. Acks go only to the owner. A stray slave ack while
  // idle reaches nobody.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign grant     = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wshb_arbiter2.sv
// tb_wshb_arbiter2
// Self-checking bench for wshb_arbiter2 with MAX_BURST=4. Each scenario task
// describes its stimulus cycle by cycle: what both masters drive and which
// grant and ack are expected. The expected bus view is pushed to a scoreboard
// queue while the stimulus is driven. It is popped and compared against the
// DUT outputs on the falling edge of the same cycle.
module tb_wshb_arbiter2;

  localparam int MAX_BURST = 4;
  localparam int ADR_WIDTH = 32;
  localparam logic [2:0] CTI_CLS = 3'b000;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  logic clk = 1'b0;
  logic rst;

  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic [2:0]  m0_cti;
  logic [1:0]  m0_bte;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic [2:0]  m1_cti;
  logic [1:0]  m1_bte;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant;
  logic        spurious;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Zero-wait-state slave. Read data is derived from the address so that the
  // broadcast read path can be checked.
  assign s_ack    = (s_cyc & s_stb) | spurious;
  assign s_dat_sm = {s_adr[15:0], ~s_adr[15:0]};

  wshb_arbiter2 #(.MAX_BURST(MAX_BURST), .ADR_WIDTH(ADR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack),
    .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  typedef struct packed {
    logic [1:0]  grant;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack0;
    logic        ack1;
    logic [2:0]  cti;
    logic [3:0]  sel;
    logic [15:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat0;
    logic [15:0] rdat1;
  } obs_t;

  typedef struct packed {
    logic       c0;
    logic       we0;
    logic [2:0] cti0;
    logic       c1;
    logic       we1;
    logic [2:0] cti1;
    logic [1:0] g;
    logic       ack;
  } row_t;

  obs_t exp_q[$];

  function automatic row_t mk(input logic c0, input logic we0, input logic [2:0] cti0,
                              input logic c1, input logic we1, input logic [2:0] cti1,
                              input logic [1:0] g, input logic ack);
    mk = {c0, we0, cti0, c1, we1, cti1, g, ack};
  endfunction

  function automatic obs_t sample();
    sample = {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, s_cti, s_sel,
              s_adr[15:0], s_dat_ms[15:0], m0_dat_sm[15:0], m1_dat_sm[15:0]};
  endfunction

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0;
    m0_dat_ms = '0; m0_cti = '0; m0_bte = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0;
    m1_dat_ms = '0; m1_cti = '0; m1_bte = '0;
    spurious = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one cycle of master stimulus and pushes the expected bus view.
  // A master that is not requesting drives all zeros. Master 0 walks its
  // address; master 1 always targets 0x100.
  task automatic drive_row(input row_t r, input int i);
    obs_t e;
    m0_cyc    = r.c0;
    m0_stb    = r.c0;
    m0_we     = r.c0 & r.we0;
    m0_adr    = r.c0 ? 32'h1000 + 32'(4 * i) : '0;
    m0_dat_ms = r.c0 ? 32'hA000 + 32'(i) : '0;
    m0_sel    = r.c0 ? 4'hF : 4'h0;
    m0_cti    = r.c0 ? r.cti0 : 3'b000;
    m1_cyc    = r.c1;
    m1_stb    = r.c1;
    m1_we     = r.c1 & r.we1;
    m1_adr    = r.c1 ? 32'h100 : '0;
    m1_dat_ms = r.c1 ? 32'hB000 + 32'(i) : '0;
    m1_sel    = r.c1 ? 4'h3 : 4'h0;
    m1_cti    = r.c1 ? r.cti1 : 3'b000;
    e = '0;
    e.grant = r.g;
    e.ack0  = (r.g == 2'b01) & r.ack;
    e.ack1  = (r.g == 2'b10) & r.ack;
    if (r.g == 2'b01) begin
      e.cyc = m0_cyc; e.stb = m0_stb; e.we = m0_we; e.cti = m0_cti;
      e.sel = m0_sel; e.adr = m0_adr[15:0]; e.wdat = m0_dat_ms[15:0];
    end else if (r.g == 2'b10) begin
      e.cyc = m1_cyc; e.stb = m1_stb; e.we = m1_we; e.cti = m1_cti;
      e.sel = m1_sel; e.adr = m1_adr[15:0]; e.wdat = m1_dat_ms[15:0];
    end
    e.rdat0 = ~e.adr;
    e.rdat1 = ~e.adr;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin fails++; $display("[TB] FAIL reset_grant got %b want 00", grant); end
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin fails++; $display("[TB] FAIL reset_cyc got %b%b want 00", s_cyc, s_stb); end
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2000; m0_sel = 4'hF;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || m0_ack !== 1'b0 || s_adr !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_held got grant=%b ack=%b adr=%h want 00/0/0", grant, m0_ack, s_adr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || m0_ack !== 1'b1 || s_adr !== 32'h2000) begin
      fails++; $display("[TB] FAIL reset_first_grant got grant=%b ack=%b adr=%h want 01/1/2000", grant, m0_ack, s_adr);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00) begin fails++; $display("[TB] FAIL midcycle_reset_grant got %b want 00", grant); end
    checks++;
    if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin fails++; $display("[TB] FAIL midcycle_reset_cyc got cyc=%b ack=%b want 0/0", s_cyc, m0_ack); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || m0_ack !== 1'b1) begin fails++; $display("[TB] FAIL reset_regrant got grant=%b ack=%b want 01/1", grant, m0_ack); end
  endtask

  task automatic test_single_master();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b00, 0));
    for (int k = 1; k <= 8; k++) rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b10, 1));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      drive_row(rows[i], i);
      @(negedge clk);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL single_master cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_quota_preempt();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b10, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b10, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b01, 1));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      drive_row(rows[i], i);
      @(negedge clk);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL quota_preempt cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_release_on_cyc();
    row_t rows[$];
    obs_t e, o;
    int m1_acks = 0;
    do_reset();
    rows.push_back(mk(0, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b10, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b10, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b10, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b01, 1));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      drive_row(rows[i], i);
      @(negedge clk);
      if (m1_ack === 1'b1) m1_acks++;
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL release_on_cyc cyc %0d got %h want %h", i, o, e); end
    end
    checks++;
    if (m1_acks !== 2) begin fails++; $display("[TB] FAIL m1_ack_count got %0d want 2", m1_acks); end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(1, 0, CTI_CLS, 1, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 0, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(0, 0, CTI_CLS, 0, 0, CTI_CLS, 2'b01, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 0, CTI_CLS, 2'b10, 1));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      spurious = (i == 0);
      drive_row(rows[i], i);
      @(negedge clk);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL round_robin cyc %0d got %h want %h", i, o, e); end
    end
    spurious = 0;
  endtask

  task automatic test_burst_hold();
    row_t rows[$];
    obs_t e, o;
    do_reset();
    rows.push_back(mk(1, 0, CTI_INC, 0, 0, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_INC, 0, 0, CTI_CLS, 2'b01, 1));
    for (int k = 2; k <= 6; k++) rows.push_back(mk(1, 0, CTI_INC, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_END, 1, 1, CTI_CLS, 2'b01, 1));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b00, 0));
    rows.push_back(mk(1, 0, CTI_CLS, 1, 1, CTI_CLS, 2'b10, 1));
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      drive_row(rows[i], i);
      @(negedge clk);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin fails++; $display("[TB] FAIL burst_hold cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired, simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_master();
    test_quota_preempt();
    test_release_on_cyc();
    test_round_robin();
    test_burst_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
